// File: rtl/mem_pkg.sv
// Shared types and defaults for the main-memory responder and its line array.
package mem_pkg;

    localparam int ADDR_W_DEF  = 14;
    localparam int LINE_W_DEF  = 64;
    localparam int MEM_LAT_DEF = 4;

    typedef logic [LINE_W_DEF-1:0] line_t;
    typedef logic [ADDR_W_DEF-1:0] laddr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } mem_state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/line_ram.sv
// Single-port backing line array: registered read, write enable, contents survive reset.
module line_ram #(
    parameter int AW = 14,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wr_data,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_addr];
    end

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory responder: arbitrates I-side fills and D-side fills/write-backs,
// services one access at a time with fixed latency and a one-cycle ack.
module main_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_rd_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wr_data,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_rd_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    mem_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_gnt;
    logic              r_last_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wr_data;
    logic              r_i_ack;
    logic              r_d_ack;
    logic [LINE_W-1:0] r_i_rd;
    logic [LINE_W-1:0] r_d_rd;

    logic              w_pick_d;
    logic              w_done;
    logic              w_ram_we;
    logic [LINE_W-1:0] w_ram_q;

    // D wins a tie unless it won the previous grant
    assign w_pick_d = d_req && (!i_req || (r_last_gnt != GNT_D));
    assign w_done   = (r_state == ST_WAIT) && (r_cnt == '0);
    // Gated by state so a reset during WAIT can never commit a write
    assign w_ram_we = w_done && r_we;

    line_ram #(
        .AW (ADDR_W),
        .DW (LINE_W)
    ) u_line_ram (
        .clk       (clk),
        .i_we      (w_ram_we),
        .i_addr    (r_addr),
        .i_wr_data (r_wr_data),
        .o_rd_data (w_ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_gnt      <= GNT_I;
            r_last_gnt <= GNT_I;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_i_ack    <= 1'b0;
            r_d_ack    <= 1'b0;
            r_i_rd     <= '0;
            r_d_rd     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        r_gnt      <= w_pick_d ? GNT_D : GNT_I;
                        r_last_gnt <= w_pick_d ? GNT_D : GNT_I;
                        r_addr     <= w_pick_d ? d_addr : i_addr;
                        r_we       <= w_pick_d && d_we;
                        r_wr_data  <= d_wr_data;
                        r_cnt      <= CNT_W'(MEM_LAT - 1);
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_ACK;
                        if (r_gnt == GNT_I) begin
                            r_i_rd  <= w_ram_q;
                            r_i_ack <= 1'b1;
                        end else begin
                            r_d_ack <= 1'b1;
                            if (!r_we) begin
                                r_d_rd <= w_ram_q;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rd_data = r_i_rd;
    assign d_rd_data = r_d_rd;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl against a line-array model and timing rules.
module tb_main_mem_ctrl;
    import mem_pkg::*;

    localparam int AW  = 14;
    localparam int LW  = 64;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [LW-1:0] i_rd_data;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wr_data = '0;
    logic          d_ack;
    logic [LW-1:0] d_rd_data;
    logic          busy;

    main_mem_ctrl #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rd_data (i_rd_data),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wr_data (d_wr_data),
        .d_ack     (d_ack),
        .d_rd_data (d_rd_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Reference: what each line holds and what each port's rd_data should show
    logic [LW-1:0] mdl [int];
    logic [LW-1:0] exp_i_rd = '0;
    logic [LW-1:0] exp_d_rd = '0;

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: busy=%b after 50 cycles, required 0", busy);
        end
    endtask

    // Raise one request, return cycles from request to ack (-1 on timeout)
    task automatic access(input bit is_d, input bit we, input logic [AW-1:0] addr,
                          input logic [LW-1:0] wd, output int lat, output logic [LW-1:0] rd);
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wr_data = wd;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        lat = -1;
        rd  = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if ((is_d && d_ack) || (!is_d && i_ack)) begin
                lat = k;
                rd  = is_d ? d_rd_data : i_rd_data;
                break;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (i_ack !== 1'b0) begin n_bad++; $display("FAIL reset_i_ack: got %b exp 0", i_ack); end
        n_cmp++; if (d_ack !== 1'b0) begin n_bad++; $display("FAIL reset_d_ack: got %b exp 0", d_ack); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_cmp++; if (i_rd_data !== '0) begin n_bad++; $display("FAIL reset_i_rd: got %h exp 0", i_rd_data); end
        n_cmp++; if (d_rd_data !== '0) begin n_bad++; $display("FAIL reset_d_rd: got %h exp 0", d_rd_data); end
        rst = 1'b0;
        exp_i_rd = '0;
        exp_d_rd = '0;
    endtask

    task automatic test_single_fill();
        int lat;
        logic [LW-1:0] rd;
        logic [LW-1:0] v = 64'h1111_2222_3333_4444;
        wait_idle();
        access(1'b1, 1'b1, 14'h0010, v, lat, rd);
        mdl[16] = v;
        n_cmp++; if (lat !== LAT + 1) begin n_bad++; $display("FAIL preload_lat: got %0d exp %0d", lat, LAT + 1); end
        wait_idle();
        i_req = 1'b1; i_addr = 14'h0010;
        for (int k = 0; k <= LAT + 1; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (busy !== (k <= LAT)) begin n_bad++; $display("FAIL fill_busy[%0d]: got %b exp %b", k, busy, (k <= LAT)); end
            n_cmp++;
            if (i_ack !== (k == LAT)) begin n_bad++; $display("FAIL fill_ack[%0d]: got %b exp %b", k, i_ack, (k == LAT)); end
            if (k == LAT) begin
                n_cmp++;
                if (i_rd_data !== v) begin n_bad++; $display("FAIL fill_data: got %h exp %h", i_rd_data, v); end
                i_req = 1'b0;
            end
        end
        exp_i_rd = v;
    endtask

    task automatic test_write_read();
        int lat, t1, t2;
        logic [LW-1:0] rd;
        logic [LW-1:0] v = 64'hDEAD_BEEF_0000_FFFF;
        wait_idle();
        access(1'b1, 1'b1, 14'h0020, v, lat, rd);
        t1 = cyc;
        mdl[32] = v;
        n_cmp++; if (lat !== LAT + 1) begin n_bad++; $display("FAIL wb_lat: got %0d exp %0d", lat, LAT + 1); end
        access(1'b1, 1'b0, 14'h0020, '0, lat, rd);
        t2 = cyc;
        n_cmp++; if (lat < 0 || t2 - t1 !== LAT + 2) begin n_bad++; $display("FAIL raw_spacing: got %0d exp %0d", t2 - t1, LAT + 2); end
        n_cmp++; if (rd !== v) begin n_bad++; $display("FAIL raw_data: got %h exp %h", rd, v); end
        n_cmp++; if (i_rd_data !== exp_i_rd) begin n_bad++; $display("FAIL raw_i_hold: got %h exp %h", i_rd_data, exp_i_rd); end
        exp_d_rd = v;
    endtask

    task automatic test_simultaneous();
        bit order [4];
        logic [LW-1:0] data [4];
        int  n_ack = 0;
        bit  overlap = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        i_req = 1'b1; i_addr = 14'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0020;
        @(negedge clk);
        rst = 1'b0;
        exp_i_rd = '0; exp_d_rd = '0;
        for (int k = 0; k < 60 && n_ack < 4; k++) begin
            @(posedge clk); #1;
            if (i_ack && d_ack) overlap = 1'b1;
            if (i_ack || d_ack) begin
                order[n_ack] = d_ack;
                data[n_ack]  = d_ack ? d_rd_data : i_rd_data;
                n_ack++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        n_cmp++; if (n_ack !== 4) begin n_bad++; $display("FAIL sim_count: got %0d exp 4", n_ack); end
        n_cmp++; if (overlap !== 1'b0) begin n_bad++; $display("FAIL sim_overlap: got %b exp 0", overlap); end
        for (int j = 0; j < n_ack; j++) begin
            n_cmp++;
            if (order[j] !== ((j % 2) == 0)) begin n_bad++; $display("FAIL sim_order[%0d]: got d=%b exp d=%b", j, order[j], ((j % 2) == 0)); end
            n_cmp++;
            if (data[j] !== (((j % 2) == 0) ? mdl[32] : mdl[16])) begin
                n_bad++; $display("FAIL sim_data[%0d]: got %h exp %h", j, data[j], (((j % 2) == 0) ? mdl[32] : mdl[16]));
            end
        end
        exp_i_rd = mdl[16];
        exp_d_rd = mdl[32];
    endtask

    task automatic test_busy_arrival();
        int td = -1;
        int ti = -1;
        logic [LW-1:0] drd = '0;
        logic [LW-1:0] ird = '0;
        wait_idle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0010;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        i_req = 1'b1; i_addr = 14'h0020;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (d_ack) begin td = cyc; drd = d_rd_data; d_req = 1'b0; end
            if (i_ack) begin ti = cyc; ird = i_rd_data; i_req = 1'b0; break; end
        end
        i_req = 1'b0; d_req = 1'b0;
        n_cmp++; if (td < 0 || ti < 0 || ti - td !== LAT + 2) begin n_bad++; $display("FAIL arrival_spacing: got %0d exp %0d", ti - td, LAT + 2); end
        n_cmp++; if (drd !== mdl[16]) begin n_bad++; $display("FAIL arrival_d_data: got %h exp %h", drd, mdl[16]); end
        n_cmp++; if (ird !== mdl[32]) begin n_bad++; $display("FAIL arrival_i_data: got %h exp %h", ird, mdl[32]); end
        exp_d_rd = mdl[16];
        exp_i_rd = mdl[32];
    endtask

    task automatic test_reset_mid_write();
        int lat;
        bit seen = 1'b0;
        logic [LW-1:0] rd;
        wait_idle();
        access(1'b1, 1'b1, 14'h0030, 64'h5, lat, rd);
        mdl[48] = 64'h5;
        wait_idle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'h0030; d_wr_data = 64'h0BAD_0BAD_0BAD_0BAD;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        d_req = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstw_busy: got %b exp 0", busy); end
        n_cmp++; if (d_ack !== 1'b0) begin n_bad++; $display("FAIL rstw_d_ack: got %b exp 0", d_ack); end
        n_cmp++; if (d_rd_data !== '0) begin n_bad++; $display("FAIL rstw_d_rd: got %h exp 0", d_rd_data); end
        @(negedge clk);
        rst = 1'b0;
        exp_i_rd = '0; exp_d_rd = '0;
        // Reset landing in the ack cycle must drop the ack at once
        wait_idle();
        i_req = 1'b1; i_addr = 14'h0030;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (i_ack) begin seen = 1'b1; break; end
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (seen !== 1'b1 || i_ack !== 1'b0) begin n_bad++; $display("FAIL rsta_i_ack: seen=%b ack=%b exp seen=1 ack=0", seen, i_ack); end
        @(negedge clk);
        i_req = 1'b0;
        rst = 1'b0;
        wait_idle();
        access(1'b0, 1'b0, 14'h0030, '0, lat, rd);
        n_cmp++; if (rd !== 64'h5) begin n_bad++; $display("FAIL rstw_keep: got %h exp %h", rd, 64'h5); end
        n_cmp++; if (lat !== LAT + 1) begin n_bad++; $display("FAIL rstw_lat: got %0d exp %0d", lat, LAT + 1); end
        exp_i_rd = 64'h5;
    endtask

    task automatic test_churn();
        int lat;
        logic [LW-1:0] rd;
        logic [LW-1:0] v;
        bit acked = 1'b0;
        for (int a = 64; a < 69; a++) begin
            v = {$urandom, $urandom};
            wait_idle();
            access(1'b1, 1'b1, AW'(a), v, lat, rd);
            mdl[a] = v;
        end
        v = 64'hC0FF_EE00_1234_5678;
        wait_idle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 14'h0040; d_wr_data = v;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (d_ack) begin acked = 1'b1; break; end
            d_addr = AW'(65 + (k % 4));
            d_wr_data = {$urandom, $urandom};
        end
        d_req = 1'b0;
        mdl[64] = v;
        n_cmp++; if (acked !== 1'b1) begin n_bad++; $display("FAIL churn_ack: got %b exp 1", acked); end
        for (int a = 64; a < 69; a++) begin
            wait_idle();
            access(1'b1, 1'b0, AW'(a), '0, lat, rd);
            n_cmp++;
            if (rd !== mdl[a]) begin n_bad++; $display("FAIL churn_line[%0h]: got %h exp %h", a, rd, mdl[a]); end
            exp_d_rd = mdl[a];
        end
    endtask

    task automatic test_random();
        int lat;
        logic [LW-1:0] rd;
        logic [LW-1:0] v;
        bit is_d, we;
        int a;
        for (int j = 0; j < 32; j++) begin
            a    = 80 + int'($urandom_range(0, 7));
            is_d = (j < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            we   = (j < 8) ? 1'b1 : (is_d && 1'($urandom_range(0, 1)));
            if (j < 8) a = 80 + j;
            v = {$urandom, $urandom};
            wait_idle();
            access(is_d, we, AW'(a), v, lat, rd);
            n_cmp++;
            if (lat !== LAT + 1) begin n_bad++; $display("FAIL rand_lat[%0d]: got %0d exp %0d", j, lat, LAT + 1); end
            if (we) begin
                mdl[a] = v;
                n_cmp++;
                if (d_rd_data !== exp_d_rd) begin n_bad++; $display("FAIL rand_wb_hold[%0d]: got %h exp %h", j, d_rd_data, exp_d_rd); end
            end else begin
                n_cmp++;
                if (rd !== mdl[a]) begin n_bad++; $display("FAIL rand_data[%0d]: got %h exp %h", j, rd, mdl[a]); end
                if (is_d) exp_d_rd = mdl[a];
                else      exp_i_rd = mdl[a];
            end
            n_cmp++;
            if (is_d ? (i_rd_data !== exp_i_rd) : (d_rd_data !== exp_d_rd)) begin
                n_bad++; $display("FAIL rand_other_hold[%0d]: got i=%h d=%h exp i=%h d=%h", j, i_rd_data, d_rd_data, exp_i_rd, exp_d_rd);
            end
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        test_reset();
        test_single_fill();
        test_write_read();
        test_simultaneous();
        test_busy_arrival();
        test_reset_mid_write();
        test_churn();
        test_random();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/main_mem_ctrl.md
# main_mem_ctrl

Main-memory responder for the five-stage pipeline's instruction and data caches. It accepts line-fill reads from the I-side port and line-fill reads or dirty-line write-backs from the D-side port. It arbitrates between the two and services one access at a time with a fixed multi-cycle latency. It answers each access with a single-cycle acknowledge, and the cache controllers hold their stall on that acknowledge. It sits below IF_Unit's and MEM_Unit's caches and is the only owner of the backing line array.

## Interface
- `ADDR_W`, default 14: line address width (16-bit word address with the 2 word-offset bits dropped).
- `LINE_W`, default 64: line width, four 16-bit words.
- `MEM_LAT`, default 4: cycles from accept to ack. Legal values are ≥2.
- `clk` input, 1 bit: the single clock. All state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `i_req` input, 1 bit: I-side line-fill request. Held high until `i_ack`.
- `i_addr` input, `ADDR_W` bits: I-side line address.
- `i_ack` output, 1 bit: one-cycle pulse; `i_rd_data` is valid while it is high.
- `i_rd_data` output, `LINE_W` bits: I-side fill data.
- `d_req` input, 1 bit: D-side request. Held high until `d_ack`.
- `d_we` input, 1 bit: 1 selects write-back, 0 selects line fill.
- `d_addr` input, `ADDR_W` bits: D-side line address.
- `d_wr_data` input, `LINE_W` bits: write-back line.
- `d_ack` output, 1 bit: one-cycle completion pulse.
- `d_rd_data` output, `LINE_W` bits: D-side fill data.
- `busy` output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, WAIT, ACK.
- **IDLE:**
  - If either request is high, accept one, latch its port/addr/we/wr_data, load the counter with `MEM_LAT`-1, and go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT:**
  - Decrement the counter each cycle.
  - When the counter reaches 0, go to ACK.
  - On that same edge, register the read line into the granted port's rd_data, or commit the write into the array.
- **ACK:**
  - The granted port's ack is high for exactly this one cycle.
  - Unconditional return to IDLE.
- **Arbitration:**
  - If only one request is high, grant it.
  - If both are high, grant D, unless the previous grant was D. In that case grant I.
  - `last_grant` resets to I.
- Inputs are sampled only at the accept edge. Changes to addr/data/we while in WAIT are ignored.
- A request dropped before its ack is a protocol violation. The access still completes: a write commits and the ack still pulses.
- Both acks are never high together.
- `d_we`=1 never updates `d_rd_data`.
- Each rd_data register holds its value until that port's next read completion.
- Array contents are unaffected by reset.

## Timing
- Reset values: `i_ack`=0, `d_ack`=0, `i_rd_data`=0, `d_rd_data`=0, `busy`=0, state=IDLE, counter=0, `last_grant`=I.
- Request seen high at edge E0:
  - `busy` rises after E0.
  - ack is high in the cycle following edge E0+`MEM_LAT`.
  - State is IDLE after edge E0+`MEM_LAT`+1.
  - The next accept is at edge E0+`MEM_LAT`+2 at the earliest.
- Back-to-back throughput is one access per `MEM_LAT`+2 cycles.
- A request arriving while `busy` is high waits; it is not lost.
- Reset asserted mid-access:
  - Abort immediately; no write commit.
  - Acks are forced to 0 asynchronously.
  - The pending request is re-arbitrated from IDLE after reset releases.
- Read-after-write to the same line returns the new data: the write commits before the read is accepted.

## Structure
- Shared package `mem_pkg`:
  - `line_t` (`LINE_W`-bit), `laddr_t`.
  - FSM state enum `mem_state_t`.
  - Grant encoding constants `GNT_I`/`GNT_D`.
  - Default `MEM_LAT`.
- One sub-module, `line_ram`:
  - Synchronous single-port array, 2^`ADDR_W` × `LINE_W`.
  - Registered read, write enable, no reset.
  - The FSM, arbiter, and counter stay in `main_mem_ctrl`.

## Test plan
- **Single fill:** preload line 0x0010=0x1111_2222_3333_4444; `i_req` at edge 0 → `i_ack` high in the cycle after edge 4 with `i_rd_data`=0x1111_2222_3333_4444; `busy` high edges 0–5.
- **Write then read:** D write-back 0x0020 ← 0xDEAD_BEEF_0000_FFFF, then D fill of 0x0020 → `d_rd_data`=0xDEAD_BEEF_0000_FFFF; second ack 6 cycles after the first; `i_rd_data` unchanged.
- **Simultaneous requests:** `i_req` and `d_req` both high at reset exit → D served first, then I. Hold both high continuously → grants alternate D, I, D, I, and no ack overlap.
- **Busy arrival:** `i_req` rises 2 cycles after a D accept → I accepted at the D ack edge + 2; `i_ack` 4 cycles after that.
- **Reset mid-write:** assert `rst` during WAIT of a write-back to 0x0030 (old 0x5) → acks 0 immediately; line 0x0030 still reads 0x5 after recovery.
- **Input churn:** change `d_addr` and `d_wr_data` every cycle during WAIT → only the values present at the accept edge are written.
